// File: rtl/bcd_counter_scanner.sv
// rtl/bcd_counter_scanner.sv - multi-digit BCD up/down counter with multiplexed digit scan
//
// Purpose: counts events in BCD (clr > load > en priority) and time-multiplexes
//          the digits onto a single 4-bit digit bus with active-low digit enables.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        count enable, one count per cycle
//   up        1 = increment, 0 = decrement
//   clr       synchronous clear of the count
//   load      synchronous load of load_val (nibbles above 9 clamp to 9)
//   load_val  BCD load value, nibble i = digit i
//   bcd       registered count
//   carry     one-cycle pulse on wrap in either direction
//   A         registered digit for the seven-segment decoder
//   AN        active-low digit enables (one low bit, or all high)
//   slot      index of the digit currently displayed
// Build option: define LEADING_ZERO_BLANK_EN to blank leading-zero digits.

module bcd_counter_scanner #(
    parameter int NDIGITS  = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   up,
    input  logic                   clr,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    output logic [4*NDIGITS-1:0]   bcd,
    output logic                   carry,
    output logic [3:0]             A,
    output logic [NDIGITS-1:0]     AN,
    output logic [2:0]             slot
);

    localparam int             PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [2:0]     PTR_MAX   = 3'(NDIGITS - 1);

    logic [4*NDIGITS-1:0] step_val;
    logic                 step_wrap;
    logic [4*NDIGITS-1:0] clamp_val;
    logic [PW-1:0]        presc;
    logic [2:0]           ptr;
    logic                 tick;
    logic [3:0]           cur_digit;
    logic [NDIGITS-1:0]   an_next;

    // Ripple BCD increment/decrement; the carry/borrow surviving past the
    // top digit is exactly the wrap condition.
    always_comb begin
        logic       c;
        logic [3:0] d;
        step_val = bcd;
        c        = 1'b1;
        d        = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            d = bcd[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d == 4'd9) d = 4'd0;
                    else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) d = 4'd9;
                    else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            step_val[4*i +: 4] = d;
        end
        step_wrap = c;
    end

    always_comb begin
        clamp_val = load_val;
        for (int i = 0; i < NDIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) clamp_val[4*i +: 4] = 4'd9;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd   <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            bcd   <= '0;
            carry <= 1'b0;
        end else if (load) begin
            bcd   <= clamp_val;
            carry <= 1'b0;
        end else if (en) begin
            bcd   <= step_val;
            carry <= step_wrap;
        end else begin
            carry <= 1'b0;
        end
    end

    assign tick = (presc == PRESC_MAX);

    // Constant-index mux keeps every select in range for any NDIGITS.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (ptr == 3'(i)) cur_digit = bcd[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic hi_zero;

    // Blank when the scanned digit and every digit above it are zero;
    // digit 0 always shows so a zero count reads "0".
    always_comb begin
        hi_zero = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((3'(i) >= ptr) && (bcd[4*i +: 4] != 4'd0)) hi_zero = 1'b0;
        end
        an_next = '1;
        if (!(hi_zero && (ptr != 3'd0))) begin
            for (int i = 0; i < NDIGITS; i++) begin
                an_next[i] = (ptr != 3'(i));
            end
        end
    end
`else
    always_comb begin
        an_next = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            an_next[i] = (ptr != 3'(i));
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            ptr   <= 3'd0;
            A     <= 4'd0;
            AN    <= '1;
            slot  <= 3'd0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                A    <= cur_digit;
                AN   <= an_next;
                slot <= ptr;
                ptr  <= (ptr == PTR_MAX) ? 3'd0 : ptr + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_scanner.sv
// tb/tb_bcd_counter_scanner.sv - self-checking bench for bcd_counter_scanner

module tb_bcd_counter_scanner;

    localparam int ND  = 4;
    localparam int DIV = 4;

    logic          clk;
    logic          rst_n;
    logic          en, up, clr, load;
    logic [15:0]   load_val;
    logic [15:0]   bcd;
    logic          carry;
    logic [3:0]    A;
    logic [3:0]    AN;
    logic [2:0]    slot;

    int total = 0;
    int bad   = 0;

    // reference state: count as a plain integer, display as expected values
    int          cnt;
    logic        exp_carry;
    int          cyc;
    logic [3:0]  exp_a;
    logic [3:0]  exp_an;
    logic [2:0]  exp_slot;

    bcd_counter_scanner #(.NDIGITS(ND), .SCAN_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd), .carry(carry), .A(A), .AN(AN), .slot(slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic int clamp_to_int(input logic [15:0] v);
        int s;
        int n;
        s = 0;
        for (int i = 0; i < ND; i++) begin
            n = int'(v[4*i +: 4]);
            if (n > 9) n = 9;
            s = s + n * (10 ** i);
        end
        return s;
    endfunction

    // One clock: advance the reference from the current inputs, then compare
    task automatic step();
        int prev;
        int p;
        prev = cnt;
        if (clr) begin
            cnt = 0; exp_carry = 1'b0;
        end else if (load) begin
            cnt = clamp_to_int(load_val); exp_carry = 1'b0;
        end else if (en) begin
            if (up) begin
                exp_carry = (cnt == 9999);
                cnt = (cnt + 1) % 10000;
            end else begin
                exp_carry = (cnt == 0);
                cnt = (cnt + 9999) % 10000;
            end
        end else begin
            exp_carry = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc % DIV == 0) begin
            p = (cyc / DIV - 1) % ND;
            exp_a    = 4'((prev / (10 ** p)) % 10);
            exp_an   = ~(4'b0001 << p);
            exp_slot = 3'(p);
`ifdef LEADING_ZERO_BLANK_EN
            if (p > 0 && prev < 10 ** p) exp_an = 4'hF;
`endif
        end
        total++; if (bcd !== to_bcd(cnt)) begin bad++; $display("FAIL model_bcd cyc=%0d got=%h exp=%h", cyc, bcd, to_bcd(cnt)); end
        total++; if (carry !== exp_carry) begin bad++; $display("FAIL model_carry cyc=%0d got=%b exp=%b", cyc, carry, exp_carry); end
        total++; if (A !== exp_a) begin bad++; $display("FAIL model_A cyc=%0d got=%h exp=%h", cyc, A, exp_a); end
        total++; if (AN !== exp_an) begin bad++; $display("FAIL model_AN cyc=%0d got=%b exp=%b", cyc, AN, exp_an); end
        total++; if (slot !== exp_slot) begin bad++; $display("FAIL model_slot cyc=%0d got=%0d exp=%0d", cyc, slot, exp_slot); end
        total++; if ($countones(~AN) > 1) begin bad++; $display("FAIL an_onehot cyc=%0d got=%b exp=at most one low", cyc, AN); end
    endtask

    task automatic idle_inputs();
        en = 0; up = 0; clr = 0; load = 0; load_val = '0;
    endtask

    task automatic model_reset();
        cnt = 0; exp_carry = 0; cyc = 0; exp_a = 0; exp_an = 4'hF; exp_slot = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++; if (bcd !== 16'h0) begin bad++; $display("FAIL %s_bcd got=%h exp=0000", tag, bcd); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL %s_carry got=%b exp=0", tag, carry); end
        total++; if (A !== 4'h0) begin bad++; $display("FAIL %s_A got=%h exp=0", tag, A); end
        total++; if (AN !== 4'hF) begin bad++; $display("FAIL %s_AN got=%b exp=1111", tag, AN); end
        total++; if (slot !== 3'd0) begin bad++; $display("FAIL %s_slot got=%0d exp=0", tag, slot); end
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_scan();
        logic [3:0] want [4];
        apply_reset();
        load = 1; load_val = 16'h1000;
        step();
        idle_inputs();
        for (int k = 2; k <= 3; k++) begin
            step();
            total++; if (AN !== 4'hF) begin bad++; $display("FAIL scan_pre_tick cyc=%0d got=%b exp=1111", k, AN); end
        end
        want[0] = 4'hE; want[1] = 4'hD; want[2] = 4'hB; want[3] = 4'h7;
        for (int t = 0; t < 5; t++) begin
            step();
            total++; if (AN !== want[t % 4]) begin bad++; $display("FAIL scan_an tick=%0d got=%b exp=%b", t, AN, want[t % 4]); end
            total++; if (slot !== 3'(t % 4)) begin bad++; $display("FAIL scan_slot tick=%0d got=%0d exp=%0d", t, slot, t % 4); end
            if (t < 4) repeat (DIV - 1) step();
        end
    endtask

    task automatic test_wrap_up();
        load = 1; load_val = 16'h9998; step();
        load = 0; en = 1; up = 1;
        step();
        total++; if (bcd !== 16'h9999 || carry !== 1'b0) begin bad++; $display("FAIL up_9999 got=%h/%b exp=9999/0", bcd, carry); end
        step();
        total++; if (bcd !== 16'h0000 || carry !== 1'b1) begin bad++; $display("FAIL up_wrap got=%h/%b exp=0000/1", bcd, carry); end
        step();
        total++; if (bcd !== 16'h0001 || carry !== 1'b0) begin bad++; $display("FAIL up_0001 got=%h/%b exp=0001/0", bcd, carry); end
        idle_inputs();
    endtask

    task automatic test_wrap_down();
        load = 1; load_val = 16'h0000; step();
        load = 0; en = 1; up = 0;
        step();
        total++; if (bcd !== 16'h9999 || carry !== 1'b1) begin bad++; $display("FAIL down_wrap got=%h/%b exp=9999/1", bcd, carry); end
        en = 0;
        step();
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL down_pulse got=%b exp=0", carry); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        load = 1; load_val = 16'h9999; step();
        load = 0; en = 1;
        for (int k = 0; k < 3; k++) begin
            up = (k % 2 == 0);
            step();
            total++; if (carry !== 1'b1) begin bad++; $display("FAIL b2b_carry k=%0d got=%b exp=1", k, carry); end
        end
        idle_inputs();
    endtask

    task automatic test_clamp_priority();
        load = 1; load_val = 16'h1A2F; step();
        total++; if (bcd !== 16'h1929) begin bad++; $display("FAIL clamp got=%h exp=1929", bcd); end
        clr = 1; load = 1; en = 1; up = 1; load_val = 16'h4321; step();
        total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL clr_prio got=%h exp=0000", bcd); end
        clr = 0; load = 1; en = 1; load_val = 16'h0500; step();
        total++; if (bcd !== 16'h0500) begin bad++; $display("FAIL load_prio got=%h exp=0500", bcd); end
        idle_inputs();
    endtask

    task automatic test_digit_scan();
        logic [3:0] want_a  [4];
        logic [3:0] want_an [4];
        apply_reset();
        load = 1; load_val = 16'h0047; step();
        idle_inputs();
        step(); step();
        want_a[0] = 4'h7; want_a[1] = 4'h4; want_a[2] = 4'h0; want_a[3] = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
        want_an[0] = 4'hE; want_an[1] = 4'hD; want_an[2] = 4'hF; want_an[3] = 4'hF;
`else
        want_an[0] = 4'hE; want_an[1] = 4'hD; want_an[2] = 4'hB; want_an[3] = 4'h7;
`endif
        for (int t = 0; t < 4; t++) begin
            step();
            total++; if (A !== want_a[t]) begin bad++; $display("FAIL digit_A t=%0d got=%h exp=%h", t, A, want_a[t]); end
            total++; if (AN !== want_an[t]) begin bad++; $display("FAIL digit_AN t=%0d got=%b exp=%b", t, AN, want_an[t]); end
            repeat (DIV - 1) step();
        end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            clr  = (r < 4);
            load = (r >= 4 && r < 12);
            en   = ($urandom_range(0, 9) < 8);
            up   = ($urandom_range(0, 1) == 1);
            load_val = 16'($urandom);
            if ($urandom_range(0, 3) == 0) load_val = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        load = 1; load_val = 16'h5678; step();
        load = 0; en = 1; up = 1;
        repeat (6) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (DIV) step();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_scan();
        test_wrap_up();
        test_wrap_down();
        test_back_to_back();
        test_clamp_priority();
        test_digit_scan();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
